// File: rtl/push_adapter_pkg.sv
// Shared types and helpers for the clocked-to-4-phase push adapter.
package push_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } state_e;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ack_synchronizer.sv
// Multi-flop synchronizer bringing the asynchronous acknowledge into the clk domain.
module ack_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    // shift chain, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/clocked_push_adapter.sv
// Buffers words from a valid/ready producer and issues each one as a
// return-to-zero 4-phase bundled-data push on out_req/out_ack.
module clocked_push_adapter
    import push_adapter_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_req,
    input  logic                   out_ack,
    output logic [WIDTH-1:0]       out_data,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW  = count_width(DEPTH);
    localparam int PW  = $clog2(DEPTH);
    localparam int SCW = $clog2(SETUP_CYCLES + 1);
    localparam int FW  = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_in_ready;
    logic [SCW-1:0]   r_setup_cnt;
    logic [FW-1:0]    r_fill;
    logic             r_out_req;
    logic [WIDTH-1:0] r_out_data;
    logic             r_busy;
    state_e           r_state;

    state_e           w_next_state;
    logic             w_ack_s;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_next;

    ack_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk    (clk),
        .reset  (reset),
        .i_async(out_ack),
        .o_sync (w_ack_s)
    );

    assign w_push = in_valid && r_in_ready;

    // Handshake sequencing. r_fill keeps IDLE from trusting ack_s until the
    // synchronizer holds real samples again after a reset.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if ((r_count != '0) && !w_ack_s && (r_fill == '0)) begin
                    w_pop        = 1'b1;
                    w_next_state = SETUP;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SETUP: begin
                if (r_setup_cnt <= SCW'(1)) begin
                    w_next_state = REQ_HI;
                end else begin
                    w_next_state = SETUP;
                end
            end
            REQ_HI: begin
                if (w_ack_s) begin
                    w_next_state = REQ_LO;
                end else begin
                    w_next_state = REQ_HI;
                end
            end
            REQ_LO: begin
                if (!w_ack_s) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = REQ_LO;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Occupancy after this edge
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Control state, pointers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_setup_cnt <= '0;
            r_fill      <= FW'(SYNC_STAGES);
            r_out_req   <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next < CW'(DEPTH));
            r_out_req  <= (w_next_state == REQ_HI);
            r_busy     <= (w_next_state != IDLE);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + PW'(1);
                r_out_data  <= r_mem[r_rd_ptr];
                r_setup_cnt <= SCW'(SETUP_CYCLES);
            end else if (r_setup_cnt != '0) begin
                r_setup_cnt <= r_setup_cnt - SCW'(1);
            end
            if (r_fill != '0) begin
                r_fill <= r_fill - FW'(1);
            end
        end
    end

    assign in_ready = r_in_ready;
    assign out_req  = r_out_req;
    assign out_data = r_out_data;
    assign busy     = r_busy;
    assign count    = r_count;

endmodule

// File: tb/tb_clocked_push_adapter.sv
// Directed bench for clocked_push_adapter: instance 0 uses default timing,
// instance 1 uses SETUP_CYCLES=3 / SYNC_STAGES=3; each has a transaction model.
module tb_clocked_push_adapter;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [7:0] in_data [2];
    logic [1:0] out_req;
    logic [7:0] out_data [2];
    logic [1:0] busy;
    logic [2:0] count [2];
    logic [1:0] auto_en;
    logic [1:0] man_ack;
    logic [1:0] rnd_dly;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic [7:0] got0 [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge out_req[0]) got0.push_back(out_data[0]);

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int S = (g == 0) ? 1 : 3;
        localparam int N = (g == 0) ? 2 : 3;
        logic out_ack = 1'b0;

        clocked_push_adapter #(
            .WIDTH(8), .DEPTH(4), .SETUP_CYCLES(S), .SYNC_STAGES(N)
        ) dut (
            .clk(clk), .reset(rst[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_data(in_data[g]), .out_req(out_req[g]), .out_ack(out_ack),
            .out_data(out_data[g]), .busy(busy[g]), .count(count[g])
        );

        // async responder: ack mirrors req after a delay, or follows man_ack
        always begin : responder
            int unsigned dly;
            @(out_req[g] or auto_en[g] or man_ack[g]);
            if (auto_en[g]) begin
                dly = rnd_dly[g] ? $urandom_range(0, 40) : 3;
                if (dly % 10 == 0) dly = dly + 3;
                #(dly);
                out_ack = out_req[g];
            end else begin
                out_ack = man_ack[g];
            end
        end

        // transaction model: FIFO queue plus edge-numbered handshake milestones
        logic [7:0] mq [$];
        logic [7:0] m_data = 8'h00;
        bit m_busy = 1'b0;
        bit m_req  = 1'b0;
        int mk = 0, rst_e = 0, pop_e = 0, hi_e = -1, lo_e = -1;
        bit ack_hist [64];

        always @(posedge clk) begin : model
            bit rdy;
            mk++;
            ack_hist[mk % 64] = out_ack;
            if (rst[g]) begin
                mq.delete();
                m_busy = 1'b0;
                m_req  = 1'b0;
                m_data = 8'h00;
                rst_e  = mk;
            end else begin
                rdy = (mq.size() < 4);
                if (!m_busy && mq.size() > 0 && mk > rst_e + N && !ack_hist[(mk - N) % 64]) begin
                    m_data = mq.pop_front();
                    m_busy = 1'b1;
                    pop_e  = mk;
                    hi_e   = -1;
                    lo_e   = -1;
                end else if (m_busy) begin
                    if (hi_e < 0 && out_ack && mk > pop_e + S) hi_e = mk;
                    else if (hi_e >= 0 && lo_e < 0 && !out_ack) lo_e = mk;
                end
                if (in_valid[g] && rdy) mq.push_back(in_data[g]);
                m_req = m_busy && (mk >= pop_e + S) && (hi_e < 0 || mk < hi_e + N);
                if (m_busy && lo_e >= 0 && mk >= lo_e + N) begin
                    m_busy = 1'b0;
                    m_req  = 1'b0;
                end
            end
            #1;
            check($sformatf("g%0d count", g), int'(count[g]), mq.size());
            check($sformatf("g%0d in_ready", g), int'(in_ready[g]), int'(mq.size() < 4));
            check($sformatf("g%0d busy", g), int'(busy[g]), int'(m_busy));
            check($sformatf("g%0d out_req", g), int'(out_req[g]), int'(m_req));
            check($sformatf("g%0d out_data", g), int'(out_data[g]), int'(m_data));
        end
    end

    task automatic push(input int g, input logic [7:0] d);
        int i;
        for (i = 0; i < 200 && !in_ready[g]; i++) @(negedge clk);
        if (!in_ready[g]) check("push_ready_timeout", 0, 1);
        in_valid[g] = 1'b1;
        in_data[g]  = d;
        @(negedge clk);
        in_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        bit done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (count[g] == 3'd0 && !busy[g]) begin
                done = 1'b1;
                break;
            end
        end
        check("drain", int'(done), 1);
    endtask

    task automatic wait_req(input int g, output int e);
        bit done = 1'b0;
        e = -1;
        for (int i = 0; i < 100; i++) begin
            if (out_req[g]) begin
                done = 1'b1;
                e = cyc;
                break;
            end
            @(negedge clk);
        end
        check("req_timeout", int'(done), 1);
    endtask

    initial begin
        int pe, re, base, f, b1, r1, b2;
        bit pb;
        rst = 2'b11; in_valid = 2'b00; in_data[0] = 8'h00; in_data[1] = 8'h00;
        auto_en = 2'b11; man_ack = 2'b00; rnd_dly = 2'b00;
        repeat (3) @(negedge clk);
        rst = 2'b00;
        repeat (5) @(negedge clk);

        // reset values
        check("rst out_req", int'(out_req[0]), 0);
        check("rst out_data", int'(out_data[0]), 0);
        check("rst in_ready", int'(in_ready[0]), 1);
        check("rst count", int'(count[0]), 0);
        check("rst busy", int'(busy[0]), 0);

        // single word latency
        push(0, 8'hA5);
        pe = cyc;
        wait_req(0, re);
        check("req_latency", re - pe, 2);
        check("data_at_req", int'(out_data[0]), 8'hA5);
        wait_idle(0);
        check("count_after_single", int'(count[0]), 0);

        // fill and stall
        base = got0.size();
        auto_en[0] = 1'b0; man_ack[0] = 1'b0;
        for (int i = 1; i <= 5; i++) push(0, 8'(i));
        check("stall in_ready", int'(in_ready[0]), 0);
        check("stall count", int'(count[0]), 4);
        repeat (5) @(negedge clk);
        auto_en[0] = 1'b1;
        wait_idle(0);
        check("stall n_words", got0.size() - base, 5);
        for (int i = 0; i < 5; i++) check("stall order", int'(got0[base + i]), i + 1);

        // wrap-around with random gaps and responder delay
        base = got0.size();
        rnd_dly[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(0, 8'(8'h10 + i));
        end
        wait_idle(0);
        rnd_dly[0] = 1'b0;
        check("wrap n_words", got0.size() - base, 20);
        for (int i = 0; i < 20; i++) check("wrap order", int'(got0[base + i]), 8'h10 + i);

        // push and pop on the same edge at count 2
        base = got0.size();
        auto_en[0] = 1'b0; man_ack[0] = 1'b0;
        push(0, 8'h31); push(0, 8'h32); push(0, 8'h33);
        check("pp count before", int'(count[0]), 2);
        auto_en[0] = 1'b1;
        pb = 1'b0;
        for (int i = 0; i < 100 && !pb; i++) begin
            @(negedge clk);
            if (!busy[0] && count[0] == 3'd2) pb = 1'b1;
        end
        check("pp idle seen", int'(pb), 1);
        in_valid[0] = 1'b1; in_data[0] = 8'h34;
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("pp count after", int'(count[0]), 2);
        check("pp busy after", int'(busy[0]), 1);
        wait_idle(0);
        for (int i = 0; i < 4; i++) check("pp order", int'(got0[base + i]), 8'h31 + i);

        // reset in REQ_HI with ack high
        base = got0.size();
        auto_en[0] = 1'b0; man_ack[0] = 1'b0;
        push(0, 8'h55);
        wait_req(0, re);
        man_ack[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        check("mid_rst out_req", int'(out_req[0]), 0);
        check("mid_rst count", int'(count[0]), 0);
        rst[0] = 1'b0;
        push(0, 8'h66);
        for (int i = 0; i < 6; i++) begin
            check("req_held_low", int'(out_req[0]), 0);
            @(negedge clk);
        end
        man_ack[0] = 1'b0;
        f = cyc + 1;
        @(negedge clk);
        wait_req(0, re);
        check("ack_low_gap", re - f, 3);
        auto_en[0] = 1'b1;
        wait_idle(0);
        check("mid_rst n_words", got0.size() - base, 2);
        check("mid_rst last", int'(got0[got0.size() - 1]), 8'h66);

        // SETUP_CYCLES=3, SYNC_STAGES=3 instance
        push(1, 8'h77);
        in_valid[1] = 1'b1; in_data[1] = 8'h78;
        @(negedge clk);
        in_valid[1] = 1'b0;
        b1 = cyc; r1 = -1; b2 = -1; pb = busy[1];
        check("g1 busy at pop", int'(busy[1]), 1);
        for (int i = 0; i < 100 && b2 < 0; i++) begin
            @(negedge clk);
            if (out_req[1] && r1 < 0) r1 = cyc;
            if (busy[1] && !pb) b2 = cyc;
            pb = busy[1];
        end
        check("g1 setup_delay", r1 - b1, 3);
        check("g1 period", b2 - b1, 12);
        wait_idle(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clocked_push_adapter.md
# clocked_push_adapter

Clocked-to-asynchronous bridge driving a 4-phase bundled-data push channel into the self-timed datapath built from the C-element/mutex cell library (e.g. the Shifter pipeline). Accepts words from a synchronous valid/ready producer, buffers them in a small FIFO, and issues each word as one return-to-zero req/ack handshake. `out_ack` is asynchronous and passes through a synchronizer before use.

## Interface
- `WIDTH`, 8, data word width
- `DEPTH`, 4, FIFO entries; power of 2, ≥2
- `SETUP_CYCLES`, 1, clock cycles `out_data` is stable before `out_req` rises (bundling margin); ≥1
- `SYNC_STAGES`, 2, flops in the `out_ack` synchronizer; ≥2

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `in_valid` in 1: producer word valid
- `in_ready` out 1: adapter can accept
- `in_data` in WIDTH: producer word
- `out_req` out 1: 4-phase request, registered, glitch-free
- `out_ack` in 1: 4-phase acknowledge from async side, asynchronous to `clk`
- `out_data` out WIDTH: bundled data, registered
- `busy` out 1: FSM not in IDLE
- `count` out $clog2(DEPTH)+1: FIFO occupancy

## Operation
- Push: `in_valid && in_ready` at an edge writes `in_data` to the FIFO tail. `in_ready = (count < DEPTH)`, computed from registered count; no bypass when full, even if a pop happens in the same cycle.
- `ack_s` = `out_ack` after SYNC_STAGES flops; the FSM sees only `ack_s`.
- FSM states (package enum):
  - IDLE: `out_req`=0. If FIFO non-empty and `ack_s`==0: pop head into `out_data`, load setup counter with SETUP_CYCLES, go to SETUP. Otherwise stay.
  - SETUP: `out_req`=0, `out_data` held. Counter decrements each cycle; at 1, go to REQ_HI.
  - REQ_HI: `out_req`=1. When `ack_s`==1, go to REQ_LO.
  - REQ_LO: `out_req`=0. When `ack_s`==0, go to IDLE; the word is complete.
- `out_data` changes only on the IDLE→SETUP transition. It is stable from the start of SETUP until the next pop.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged and both occur. Push into an empty FIFO: pop occurs no earlier than the following cycle (no fall-through).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is tracked separately to distinguish full from empty.
- `busy` = (state != IDLE).

## Timing
- Reset values: `out_req`=0, `out_data`=0, `in_ready`=1, `count`=0, `busy`=0. Reset sets state to IDLE and clears the pointers and synchronizer flops.
- Reset mid-handshake: `out_req` drops to 0 the cycle after reset is sampled and the in-flight word is discarded. Because IDLE waits for `ack_s`==0, no new request is issued until the async side has returned `out_ack` low.
- Latency, empty FIFO, defaults, async ack delay negligible:
  - push at edge 0
  - pop / SETUP at edge 1
  - `out_req` rises at edge 2
  - `ack_s` high 2 edges after `out_ack` rises; REQ_LO (`out_req` low) the following edge
  - IDLE 2 edges after `out_ack` falls plus 1
- Minimum handshake period with an instant responder: 1 + SETUP_CYCLES + 2·(SYNC_STAGES+1) cycles (8 with defaults).
- `out_ack` is never used combinationally.

## Structure
- Package `push_adapter_pkg`: state enum (IDLE, SETUP, REQ_HI, REQ_LO) and a `clog2`-based count-width constant function.
- One sub-module `ack_synchronizer` (parameter SYNC_STAGES, synchronous reset to 0).
- FIFO storage and the FSM stay inline in `clocked_push_adapter`.

## Test plan
- Reset then single word: push 0xA5 with an async responder model (ack follows req after 3 ns).
  - Required: `out_data`=0xA5 before `out_req` rises, one complete 4-phase cycle, `count` returns to 0.
- Fill and stall: responder holds ack=0; push 5 words 0x01..0x05.
  - Required: `in_ready` low after the 5th accepted push (1 popped, 4 in FIFO, `count`=4).
  - Release responder: outputs 0x01..0x05 in order, no duplicates or losses.
- Wrap-around: 20 words 0x10..0x23 with random producer gaps and random responder delay (0–40 ns).
  - Required: exact in-order sequence, `out_data` never changes while `out_req`=1 or in REQ_LO.
- Simultaneous push/pop at `count`=2.
  - Required: `count` stays 2 and the data sequence is intact.
- Reset mid-operation: assert reset in REQ_HI while `out_ack`=1.
  - Required: `out_req`=0 next cycle, `count`=0.
  - No new `out_req` until `out_ack` has been low ≥ SYNC_STAGES cycles, even with a word pushed right after reset.
- SETUP_CYCLES=3, SYNC_STAGES=3.
  - Required: `out_req` rises exactly 3 cycles after the pop.
  - Handshake period = 1 + 3 + 2·4 = 12 cycles with an instant responder.
